// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver.
//   SEG_TABLE : hex digit -> active-high {g,f,e,d,c,b,a}, entry 0 is the LSB slice
//   clog2     : counter width helper, never returns less than 1
package seg7_pkg;

  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex nibble to seven-segment pattern.
//   nib : hex value 0..F
//   seg : active-high {g,f,e,d,c,b,a}
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment driver with a shadow-buffered load port.
// A word is accepted via load_valid/load_ready into a shadow register and is
// copied to the display register only on the frame wrap, so a frame never
// mixes two words.
//   clk, rst_n        : clock, synchronous active-low reset
//   load_valid/ready  : load handshake, ready = shadow empty
//   load_data/dp/blank: nibble, decimal point and force-dark per digit
//   seg, dp, dig_en   : registered display pins, polarity set by parameters
//   frame_tick        : high in the cycle the digit index wraps to 0
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 12000,
  parameter int BLANK_CYC      = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int LZ_SUPPRESS    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [4*NUM_DIGITS-1:0]   load_data,
  input  logic [NUM_DIGITS-1:0]     load_dp,
  input  logic [NUM_DIGITS-1:0]     load_blank,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     dig_en,
  output logic                      frame_tick
);

  localparam int CNT_W = clog2(REFRESH_DIV);
  localparam int DIG_W = clog2(NUM_DIGITS);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [CNT_W-1:0]        div_cnt_q, div_cnt_d;
  logic [DIG_W-1:0]        dig_idx_q, dig_idx_d;
  logic [4*NUM_DIGITS-1:0] disp_data_q, disp_data_d, sh_data_q, sh_data_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d, sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d, sh_blank_q, sh_blank_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;

  logic                    cnt_wrap, dig_last, tick, xfer, live;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank, cur_supp, hi_zero;
  logic [NUM_DIGITS-1:0]   supp, en_hi;
  logic [6:0]              lut_seg, seg_hi;
  logic                    dp_hi;

  seg7_hex_lut u_lut (.nib(cur_nib), .seg(lut_seg));

  assign cnt_wrap   = (div_cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign dig_last   = (dig_idx_q == DIG_W'(NUM_DIGITS - 1));
  // Gated by rst_n so a degenerate 1-cycle slot cannot pulse during reset.
  assign tick       = cnt_wrap && dig_last && rst_n;
  assign xfer       = load_valid && !pending_q;
  assign live       = (div_cnt_q >= CNT_W'(BLANK_CYC));
  assign load_ready = !pending_q;
  assign frame_tick = tick;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_en     = dig_en_q;

  always_comb begin
    div_cnt_d    = cnt_wrap ? '0 : div_cnt_q + CNT_W'(1);
    dig_idx_d    = dig_idx_q;
    if (cnt_wrap) dig_idx_d = dig_last ? '0 : dig_idx_q + DIG_W'(1);

    sh_data_d    = sh_data_q;
    sh_dp_d      = sh_dp_q;
    sh_blank_d   = sh_blank_q;
    pending_d    = pending_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    // xfer needs !pending, so it can never coincide with an apply; a word
    // captured in the tick cycle therefore waits for the next frame.
    if (xfer) begin
      sh_data_d  = load_data;
      sh_dp_d    = load_dp;
      sh_blank_d = load_blank;
      pending_d  = 1'b1;
    end else if (tick && pending_q) begin
      disp_data_d  = sh_data_q;
      disp_dp_d    = sh_dp_q;
      disp_blank_d = sh_blank_q;
      pending_d    = 1'b0;
    end
  end

  // Leading-zero mask: digit i is dark when it and every higher nibble is 0.
  always_comb begin
    hi_zero = 1'b1;
    supp    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hi_zero = hi_zero && (disp_data_q[4*i +: 4] == 4'h0);
      supp[i] = (LZ_SUPPRESS != 0) && (i > 0) && hi_zero;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_supp  = 1'b0;
    en_hi     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx_q == DIG_W'(i)) begin
        cur_nib   = disp_data_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = disp_blank_q[i];
        cur_supp  = supp[i];
        en_hi[i]  = live;
      end
    end
    // Suppression darkens segments only; the DP stays visible.
    seg_hi   = (live && !cur_blank && !cur_supp) ? lut_seg : 7'h00;
    dp_hi    = live && !cur_blank && cur_dp;
    seg_d    = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    dp_d     = (SEG_ACTIVE_LOW != 0) ? ~dp_hi : dp_hi;
    dig_en_d = (DIG_ACTIVE_LOW != 0) ? ~en_hi : en_hi;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      dig_idx_q    <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      dig_en_q     <= DIG_OFF;
    end else begin
      div_cnt_q    <= div_cnt_d;
      dig_idx_q    <= dig_idx_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_en_q     <= dig_en_d;
    end
  end

endmodule
